// File: rtl/instruction_fetch_pkg.sv
// Shared definitions for the fetch stage: FSM encoding, interrupt vector default
// and the base addresses of the program slots.
package instruction_fetch_pkg;

  typedef enum logic {
    S_FETCH = 1'b0,
    S_WAIT  = 1'b1
  } fetch_state_e;

  localparam int unsigned INT_VECTOR_DEFAULT = 45;

  localparam int unsigned SLOT0_BASE = 0;
  localparam int unsigned SLOT1_BASE = 15;
  localparam int unsigned SLOT2_BASE = 30;

  // The output register can take a new word when it is empty or being drained.
  function automatic logic out_free(input logic valid, input logic ready);
    return !valid || ready;
  endfunction

endpackage

// File: rtl/instruction_fetch.sv
// Fetch stage: one outstanding imem request, valid/ready output register to decode,
// and the next-address mux that feeds the program counter every clock.
module instruction_fetch
  import instruction_fetch_pkg::*;
#(
  parameter int                ADDR_W     = 32,
  parameter int                DATA_W     = 32,
  parameter logic [ADDR_W-1:0] INT_VECTOR = ADDR_W'(INT_VECTOR_DEFAULT)
) (
  input  logic              clk_i,
  input  logic              rst_ni,
  input  logic [ADDR_W-1:0] pc_i,
  output logic [ADDR_W-1:0] next_address_o,
  input  logic              redirect_i,
  input  logic [ADDR_W-1:0] redirect_target_i,
  input  logic              interrupt_i,
  output logic [ADDR_W-1:0] epc_o,
  output logic              imem_req_o,
  output logic [ADDR_W-1:0] imem_addr_o,
  input  logic              imem_ack_i,
  input  logic [DATA_W-1:0] imem_rdata_i,
  output logic              instr_valid_o,
  input  logic              instr_ready_i,
  output logic [DATA_W-1:0] instr_o,
  output logic [ADDR_W-1:0] instr_pc_o
);

  fetch_state_e      state_q, state_d;
  logic              req_q, req_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic              valid_q, valid_d;
  logic [DATA_W-1:0] instr_q, instr_d;
  logic [ADDR_W-1:0] instr_pc_q, instr_pc_d;
  logic [ADDR_W-1:0] epc_q, epc_d;
  logic              int_pending_q, int_pending_d;
  logic              discard_q, discard_d;

  logic              int_req;
  logic              free;

  assign int_req = int_pending_q | interrupt_i;
  assign free    = out_free(valid_q, instr_ready_i);

  always_comb begin
    state_d        = state_q;
    req_d          = req_q;
    addr_d         = addr_q;
    valid_d        = valid_q;
    instr_d        = instr_q;
    instr_pc_d     = instr_pc_q;
    epc_d          = epc_q;
    int_pending_d  = int_req;
    discard_d      = discard_q;
    next_address_o = pc_i;

    if (valid_q && instr_ready_i) begin
      valid_d = 1'b0;
    end

    unique case (state_q)
      S_FETCH: begin
        // An interrupt suppresses the fetch; the vector address is fetched next cycle.
        if (!redirect_i && int_req) begin
          next_address_o = INT_VECTOR;
          epc_d          = pc_i;
          int_pending_d  = 1'b0;
        end else if (!redirect_i && free) begin
          req_d   = 1'b1;
          addr_d  = pc_i;
          state_d = S_WAIT;
        end
      end

      S_WAIT: begin
        if (imem_ack_i) begin
          req_d     = 1'b0;
          state_d   = S_FETCH;
          discard_d = 1'b0;
          if (!discard_q && !redirect_i) begin
            instr_d        = imem_rdata_i;
            instr_pc_d     = addr_q;
            valid_d        = 1'b1;
            next_address_o = addr_q + ADDR_W'(1);
          end
        end else if (redirect_i) begin
          // The request cannot be withdrawn, so its data is dropped on arrival.
          discard_d = 1'b1;
        end
      end

      default: begin
        state_d = S_FETCH;
      end
    endcase

    if (redirect_i) begin
      next_address_o = redirect_target_i;
      valid_d        = 1'b0;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q       <= S_FETCH;
      req_q         <= 1'b0;
      addr_q        <= '0;
      valid_q       <= 1'b0;
      instr_q       <= '0;
      instr_pc_q    <= '0;
      epc_q         <= '0;
      int_pending_q <= 1'b0;
      discard_q     <= 1'b0;
    end else begin
      state_q       <= state_d;
      req_q         <= req_d;
      addr_q        <= addr_d;
      valid_q       <= valid_d;
      instr_q       <= instr_d;
      instr_pc_q    <= instr_pc_d;
      epc_q         <= epc_d;
      int_pending_q <= int_pending_d;
      discard_q     <= discard_d;
    end
  end

  assign imem_req_o    = req_q;
  assign imem_addr_o   = addr_q;
  assign instr_valid_o = valid_q;
  assign instr_o       = instr_q;
  assign instr_pc_o    = instr_pc_q;
  assign epc_o         = epc_q;

endmodule

// File: tb/tb_instruction_fetch.sv
// Bench for instruction_fetch: acts as program counter and instruction memory,
// scoreboards delivered words against the memory image.
module tb_instruction_fetch;
  import instruction_fetch_pkg::*;

  localparam int AW = 32;
  localparam int DW = 32;

  logic          clk = 1'b0;
  logic          rst_n;
  logic [AW-1:0] pc, next_address, redirect_target, epc, imem_addr, instr_pc;
  logic          redirect, interrupt, imem_req, imem_ack, instr_valid, instr_ready;
  logic [DW-1:0] imem_rdata, instr;

  always #5 clk = ~clk;

  instruction_fetch #(.ADDR_W(AW), .DATA_W(DW)) dut (
    .clk_i            (clk),
    .rst_ni           (rst_n),
    .pc_i             (pc),
    .next_address_o   (next_address),
    .redirect_i       (redirect),
    .redirect_target_i(redirect_target),
    .interrupt_i      (interrupt),
    .epc_o            (epc),
    .imem_req_o       (imem_req),
    .imem_addr_o      (imem_addr),
    .imem_ack_i       (imem_ack),
    .imem_rdata_i     (imem_rdata),
    .instr_valid_o    (instr_valid),
    .instr_ready_i    (instr_ready),
    .instr_o          (instr),
    .instr_pc_o       (instr_pc)
  );

  typedef struct packed {
    logic [AW-1:0] addr;
    logic [DW-1:0] data;
  } txn_t;

  txn_t          sb[$];
  int            total = 0;
  int            bad = 0;
  int            lat = 1;
  int            req_age = 0;
  logic          flush_exp = 1'b0;
  logic          req_first = 1'b0;
  logic [AW-1:0] nxt_cap;

  function automatic logic [DW-1:0] mem_word(input logic [AW-1:0] a);
    return (a == '0) ? 32'h2008_0005 : (32'hC300_0000 ^ a);
  endfunction

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // One clock: scoreboard bookkeeping before the edge, pc load and memory response after.
  task automatic tick();
    logic          p_req, p_ack;
    logic [AW-1:0] p_addr, p_pc;
    txn_t          t;
    #1;
    nxt_cap = next_address;
    p_req   = imem_req;
    p_ack   = imem_ack;
    p_addr  = imem_addr;
    p_pc    = pc;
    if (instr_valid && instr_ready) begin
      if (sb.size() == 0) begin
        check("consume_unexpected", 1, 0);
      end else begin
        t = sb.pop_front();
        $display("txn pc=%08h instr=%08h", instr_pc, instr);
        check("instr", instr, t.data);
        check("instr_pc", instr_pc, t.addr);
      end
    end else if (redirect && sb.size() != 0) begin
      void'(sb.pop_front());
    end
    if (p_req && p_ack) begin
      if (!redirect && !flush_exp) begin
        t.addr = p_addr;
        t.data = mem_word(p_addr);
        sb.push_back(t);
      end
      flush_exp = 1'b0;
    end else if (p_req && redirect) begin
      flush_exp = 1'b1;
    end

    @(posedge clk);
    #1;
    pc = nxt_cap;
    if (p_req && !p_ack) begin
      check("req_hold", imem_req, 1);
      check("addr_hold", imem_addr, p_addr);
    end
    if (p_req && p_ack) check("req_drop", imem_req, 0);
    req_first = !p_req && imem_req;
    if (req_first) check("issue_addr", imem_addr, p_pc);

    if (imem_req) begin
      req_age++;
      if (req_age >= lat) begin
        imem_ack   = 1'b1;
        imem_rdata = mem_word(imem_addr);
        req_age    = 0;
      end else begin
        imem_ack   = 1'b0;
        imem_rdata = 32'hDEAD_BEEF;
      end
    end else begin
      req_age  = 0;
      imem_ack = 1'b0;
    end
    #3;
    check("valid", instr_valid, sb.size() != 0);
  endtask

  task automatic wait_issue();
    logic got;
    got = 1'b0;
    for (int i = 0; i < 30; i++) begin
      tick();
      if (req_first) begin
        got = 1'b1;
        break;
      end
    end
    if (!got) check("issue_timeout", 0, 1);
  endtask

  task automatic redir(input logic [AW-1:0] target);
    redirect        = 1'b1;
    redirect_target = target;
    tick();
    redirect        = 1'b0;
  endtask

  initial begin
    #5000;
    $display("FAIL watchdog timeout");
    $fatal(1);
  end

  initial begin
    int vcount;
    logic got;
    rst_n = 1'b0; pc = '0; redirect = 1'b0; redirect_target = '0; interrupt = 1'b0;
    imem_ack = 1'b0; imem_rdata = '0; instr_ready = 1'b1; lat = 1;

    @(negedge clk);
    check("rst_req", imem_req, 0);
    check("rst_addr", imem_addr, 0);
    check("rst_valid", instr_valid, 0);
    check("rst_instr", instr, 0);
    check("rst_instr_pc", instr_pc, 0);
    check("rst_epc", epc, 0);
    rst_n = 1'b1;
    #1;
    check("t1_next0", next_address, 0);

    // Basic fetch with single-cycle ack.
    tick();
    check("t1_req", imem_req, 1);
    check("t1_addr", imem_addr, 0);
    check("t1_next_inc", next_address, 1);
    tick();
    tick();

    // Three-cycle memory latency.
    lat = 3;
    wait_issue();
    check("t2_hold0", next_address, pc);
    tick();
    check("t2_hold1", next_address, pc);
    tick();
    check("t2_ack", imem_ack, 1);
    check("t2_inc", next_address, pc + 32'd1);
    vcount = 0;
    for (int i = 0; i < 4; i++) begin
      tick();
      vcount += int'(instr_valid);
    end
    check("t2_one_valid", vcount, 1);

    // Decode back-pressure.
    lat = 1;
    instr_ready = 1'b0;
    got = 1'b0;
    for (int i = 0; i < 20; i++) begin
      if (instr_valid) begin
        got = 1'b1;
        break;
      end
      tick();
    end
    check("t3_valid_seen", got, 1);
    for (int i = 0; i < 4; i++) begin
      check("t3_no_req", imem_req, 0);
      if (sb.size() != 0) check("t3_hold", instr, sb[0].data);
      tick();
    end
    instr_ready = 1'b1;
    tick();
    check("t3_resume", imem_req, 1);

    // Redirect during WAIT drops the in-flight word.
    lat = 3;
    redir(32'd5);
    wait_issue();
    check("t4_addr5", imem_addr, 5);
    redirect = 1'b1;
    redirect_target = AW'(SLOT2_BASE);
    #1;
    check("t4_next_tgt", next_address, 30);
    tick();
    redirect = 1'b0;
    wait_issue();
    check("t4_addr30", imem_addr, 30);

    // Redirect on the ack cycle.
    lat = 1;
    wait_issue();
    redirect = 1'b1;
    redirect_target = AW'(SLOT1_BASE);
    #1;
    check("t4b_next_tgt", next_address, 15);
    tick();
    redirect = 1'b0;
    wait_issue();
    check("t4b_addr15", imem_addr, 15);

    // Interrupt pulse during WAIT, then a redirect that defers it.
    lat = 2;
    redir(32'd16);
    wait_issue();
    check("t5_addr16", imem_addr, 16);
    interrupt = 1'b1;
    tick();
    interrupt = 1'b0;
    check("t5_next17", next_address, 17);
    tick();
    check("t5_vec", next_address, 45);
    tick();
    check("t5_epc", epc, 17);
    check("t5_noreq", imem_req, 0);
    wait_issue();
    check("t5_addr45", imem_addr, 45);
    interrupt = 1'b1;
    tick();
    interrupt = 1'b0;
    tick();
    redirect = 1'b1;
    redirect_target = AW'(SLOT0_BASE);
    #1;
    check("t5_redir_wins", next_address, 0);
    tick();
    redirect = 1'b0;
    #1;
    check("t5_epc_keep", epc, 17);
    check("t5_deferred", next_address, 45);
    tick();
    check("t5_epc0", epc, 0);

    // Address wrap and reset during a pending request.
    lat = 1;
    redir(32'hFFFF_FFFF);
    wait_issue();
    check("t6_addr_max", imem_addr, 32'hFFFF_FFFF);
    check("t6_wrap", next_address, 0);
    tick();
    tick();
    lat = 6;
    wait_issue();
    #1;
    rst_n = 1'b0;
    #1;
    check("t6_rst_req", imem_req, 0);
    check("t6_rst_valid", instr_valid, 0);
    check("t6_rst_epc", epc, 0);
    sb.delete();
    flush_exp = 1'b0;
    req_age = 0;
    imem_ack = 1'b0;
    pc = '0;
    @(negedge clk);
    rst_n = 1'b1;
    lat = 1;
    wait_issue();
    check("t6_addr_after_rst", imem_addr, 0);
    tick();
    tick();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
